// File: rtl/agc_servo.sv
// Closed-loop AGC servo: counts per-lane threshold crossings over a window,
// then steps the DSP scale/offset toward targets and strobes load/apply.
module agc_servo #(
    parameter int          NSAMP       = 8,
    parameter int          CNT_BITS    = 24,
    parameter logic [16:0] SCALE_RESET = 17'h01000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [NSAMP-1:0]    gt_i,
    input  logic [NSAMP-1:0]    lt_i,
    input  logic [CNT_BITS-1:0] period_i,
    input  logic [CNT_BITS-1:0] target_hi_i,
    input  logic [CNT_BITS-1:0] target_lo_i,
    input  logic [16:0]         scale_step_i,
    input  logic [15:0]         offset_step_i,
    output logic [16:0]         scale_o,
    output logic [15:0]         offset_o,
    output logic                ce_scale_o,
    output logic                ce_offset_o,
    output logic                apply_o,
    output logic [CNT_BITS-1:0] gt_count_o,
    output logic [CNT_BITS-1:0] lt_count_o,
    output logic                done_o
);

    localparam int PC_W = $clog2(NSAMP + 1);
    localparam logic signed [17:0] OFF_MIN = -18'sd32768;
    localparam logic signed [17:0] OFF_MAX = 18'sd32767;

    typedef enum logic [2:0] {IDLE, ACCUM, DECIDE, LOAD, APPLY} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] gt_cnt;
    logic [CNT_BITS-1:0] lt_cnt;
    logic [CNT_BITS-1:0] win_cnt;
    logic [CNT_BITS-1:0] win_load;
    logic [CNT_BITS:0]   total;
    logic [17:0]         scale_dn;
    logic [17:0]         scale_up;
    logic [16:0]         scale_nxt;
    logic signed [17:0]  off_ext;
    logic signed [17:0]  off_step;
    logic signed [17:0]  off_dn;
    logic signed [17:0]  off_up;
    logic [15:0]         offset_nxt;

    function automatic logic [PC_W-1:0] popcount(input logic [NSAMP-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NSAMP; i++)
            n = n + PC_W'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                    input logic [PC_W-1:0]     b);
        logic [CNT_BITS:0] s;
        s = {1'b0, a} + (CNT_BITS + 1)'(b);
        return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
    endfunction

    assign win_load = (period_i == '0) ? CNT_BITS'(1) : period_i;

    // Step arithmetic is carried wide enough that the overflow/underflow bit
    // selects the clamp value directly.
    always_comb begin
        total    = {1'b0, gt_cnt} + {1'b0, lt_cnt};
        scale_dn = {1'b0, scale_o} - {1'b0, scale_step_i};
        scale_up = {1'b0, scale_o} + {1'b0, scale_step_i};
        off_ext  = {{2{offset_o[15]}}, offset_o};
        off_step = $signed({2'b00, offset_step_i});
        off_dn   = off_ext - off_step;
        off_up   = off_ext + off_step;

        scale_nxt = scale_o;
        if (total > {1'b0, target_hi_i})
            scale_nxt = scale_dn[17] ? '0 : scale_dn[16:0];
        else if (total < {1'b0, target_lo_i})
            scale_nxt = scale_up[17] ? '1 : scale_up[16:0];

        offset_nxt = offset_o;
        if (gt_cnt > lt_cnt)
            offset_nxt = (off_dn < OFF_MIN) ? 16'h8000 : off_dn[15:0];
        else if (lt_cnt > gt_cnt)
            offset_nxt = (off_up > OFF_MAX) ? 16'h7FFF : off_up[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            scale_o     <= SCALE_RESET;
            offset_o    <= '0;
            ce_scale_o  <= 1'b0;
            ce_offset_o <= 1'b0;
            apply_o     <= 1'b0;
            done_o      <= 1'b0;
            gt_count_o  <= '0;
            lt_count_o  <= '0;
            gt_cnt      <= '0;
            lt_cnt      <= '0;
            win_cnt     <= '0;
        end else begin
            ce_scale_o  <= 1'b0;
            ce_offset_o <= 1'b0;
            apply_o     <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) begin
                        gt_cnt  <= '0;
                        lt_cnt  <= '0;
                        win_cnt <= win_load;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    gt_cnt  <= sat_add(gt_cnt, popcount(gt_i));
                    lt_cnt  <= sat_add(lt_cnt, popcount(lt_i));
                    win_cnt <= win_cnt - CNT_BITS'(1);
                    if (win_cnt <= CNT_BITS'(1))
                        state <= DECIDE;
                end
                DECIDE: begin
                    gt_count_o  <= gt_cnt;
                    lt_count_o  <= lt_cnt;
                    scale_o     <= scale_nxt;
                    offset_o    <= offset_nxt;
                    ce_scale_o  <= 1'b1;
                    ce_offset_o <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    apply_o <= 1'b1;
                    done_o  <= 1'b1;
                    state   <= APPLY;
                end
                APPLY: begin
                    if (en_i) begin
                        gt_cnt  <= '0;
                        lt_cnt  <= '0;
                        win_cnt <= win_load;
                        state   <= ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/agc_servo.md
# agc_servo

Closed-loop AGC controller that sits directly downstream of the AGC DSP stage and feeds its scale/offset inputs back. Over a programmable window it counts saturation-side threshold crossings (gt/lt flags) from NSAMP parallel lanes, then steps the scale and offset toward targets. It loads the DSP's first-stage scale/offset registers, then issues the apply strobe that moves them to the active stage.

## Interface
Parameters:
- NSAMP, 8, parallel sample lanes per clock
- CNT_BITS, 24, width of window length, counters and targets
- SCALE_RESET, 17'h01000, scale_o reset value (1.0 in Q12)

Ports:
- clk_i  in  1  sole clock
- rst_i  in  1  reset; synchronous, active-high
- en_i  in  1  run servo loop
- gt_i  in  NSAMP  per-lane "above +threshold" flags from the DSP stage
- lt_i  in  NSAMP  per-lane "below −threshold" flags
- period_i  in  CNT_BITS  window length in clocks; 0 treated as 1
- target_hi_i  in  CNT_BITS  total-count upper bound
- target_lo_i  in  CNT_BITS  total-count lower bound
- scale_step_i  in  17  unsigned scale step
- offset_step_i  in  16  unsigned offset step (Q8.8 magnitude)
- scale_o  out  17  unsigned scale to DSP
- offset_o  out  16  signed Q8.8 offset to DSP
- ce_scale_o  out  1  scale first-stage load strobe
- ce_offset_o  out  1  offset first-stage load strobe
- apply_o  out  1  transfer to active registers
- gt_count_o  out  CNT_BITS  last completed window gt count
- lt_count_o  out  CNT_BITS  last completed window lt count
- done_o  out  1  one-cycle pulse per completed update

## Operation
- States: IDLE, ACCUM, DECIDE, LOAD, APPLY.
- IDLE: if en_i, clear gt_cnt/lt_cnt and load win_cnt = max(period_i, 1), then go to ACCUM.
- ACCUM: each clock, gt_cnt += popcount(gt_i) and lt_cnt += popcount(lt_i). Both counters saturate at 2^CNT_BITS−1. Decrement win_cnt; at win_cnt==1 (last accumulated cycle), go to DECIDE.
- en_i deasserted during ACCUM: the window still completes and the update is still applied. The servo then goes to IDLE.
- DECIDE (1 clk):
  - Latch gt_count_o and lt_count_o.
  - total = gt_cnt + lt_cnt, computed at CNT_BITS+1 bits.
  - total > target_hi_i: scale −= scale_step_i, clamped at 0.
  - total < target_lo_i: scale += scale_step_i, clamped at 17'h1FFFF.
  - Otherwise scale is unchanged. target_hi takes priority if both conditions are true.
  - gt_cnt > lt_cnt: offset −= offset_step_i, clamped at 16'h8000.
  - lt_cnt > gt_cnt: offset += offset_step_i, clamped at 16'h7FFF.
  - Equal counts: offset unchanged.
  - Arithmetic is done 1 bit wider than the operand, then clamped.
- LOAD (1 clk): ce_scale_o = ce_offset_o = 1; scale_o/offset_o already hold the new values.
- APPLY (1 clk): apply_o = done_o = 1. If en_i, clear the counters, reload win_cnt and go to ACCUM; else go to IDLE.
- Flags arriving during DECIDE/LOAD/APPLY/IDLE are ignored.
- scale_o/offset_o change only on DECIDE→LOAD and are held stable otherwise.

## Timing
- Reset values:
  - state IDLE
  - scale_o = SCALE_RESET, offset_o = 0
  - all strobes 0
  - gt_count_o = lt_count_o = 0
  - internal counters 0
- rst_i at any time, including mid-ACCUM or during LOAD, restores the reset values on the next edge. No strobe is issued in the cycle after reset.
- Loop period with en_i held: period + 3 clocks (ACCUM × period, DECIDE, LOAD, APPLY).
- First ACCUM cycle is one clock after en_i is seen high in IDLE.
- ce_*_o always precedes apply_o by exactly 1 clock, which keeps the DSP's two-deep registers coherent.
- gt_count_o/lt_count_o are valid from the LOAD cycle until the next DECIDE.
- period_i is sampled only when win_cnt is loaded. Targets and steps are sampled only in DECIDE.

## Test plan
- **Scale and offset step down:** period_i=4, gt_i=8'hFF, lt_i=0, target_hi=10, target_lo=0, scale_step=17'h100, offset_step=16'h10, en pulse → gt_count=32, lt_count=0; ce strobes 6 clocks after en sample, apply 7; scale_o=17'h0F00, offset_o=16'hFFF0.
- **Scale up with clamp:** gt_i=lt_i=0, target_lo=5, scale_step=17'h10000, en held → scale 17'h01000→17'h11000→17'h1FFFF (clamped); offset stays 0; apply every period+3 clocks.
- **Offset clamp:** lt_i=8'hFF, gt_i=0, offset_step=16'h4000, totals within targets → offset 16'h4000 then 16'h7FFF (clamped); scale unchanged.
- **Counter saturation:** CNT_BITS=8, period_i=64, gt_i=lt_i=8'hFF → gt_count=lt_count=255; offset unchanged (equal counts).
- **Reset mid-ACCUM:** assert rst_i in the 2nd ACCUM cycle → no ce/apply strobes follow; scale_o=17'h01000, offset_o=0, counts 0, state IDLE.
- **en_i drop mid-window:** drop en_i mid-ACCUM → the window completes and exactly one ce/apply/done sequence occurs, then the servo stays IDLE with no further strobes.
